phase_to_sample: RTL

PHASE_TO_SAMPLE -- requirements
Module: phase_to_sample

---
 rtl/phase_to_sample.sv | 96 +++++++++
 1 files changed

// File: rtl/phase_to_sample.sv
// Dual-channel phase-to-amplitude converter: quarter-wave magnitude table,
// 3-stage pipeline producing offset-binary samples for addr and addr+offset.
module phase_to_sample #(
    parameter int WIDTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  offset,
    input  logic              wr_en,
    input  logic [WIDTH-3:0]  wr_addr,
    input  logic [DATA_W-2:0] wr_data,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    output logic              valid
);
    localparam int                DEPTH = 1 << (WIDTH - 2);
    localparam logic [DATA_W-1:0] MID   = {1'b1, {(DATA_W-1){1'b0}}};

    // Table contents survive reset; only the pipeline is cleared.
    logic [DATA_W-2:0] table_mem [DEPTH];
    logic [2:0]        vld_reg;
    logic [WIDTH-1:0]  phase_in [2];

    assign phase_in[0] = addr;
    assign phase_in[1] = addr + offset;

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[1:0], en};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : ch
            logic [WIDTH-1:0]  p_reg;
            logic [1:0]        q_reg;
            logic [DATA_W-2:0] mag_reg;
            logic [DATA_W-1:0] dout_reg;
            logic [WIDTH-3:0]  idx;
            logic [DATA_W-1:0] mag_ext;

            // Odd quadrants walk the table backwards to mirror the quarter wave.
            assign idx     = p_reg[WIDTH-2] ? ~p_reg[WIDTH-3:0] : p_reg[WIDTH-3:0];
            assign mag_ext = {1'b0, mag_reg};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_reg <= '0;
                end else if (en) begin
                    p_reg <= phase_in[gi];
                end
            end

            // Registered read with no reset so the table maps onto block RAM.
            always_ff @(posedge clk) begin
                if (vld_reg[0]) begin
                    mag_reg <= table_mem[idx];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (vld_reg[0]) begin
                    q_reg <= p_reg[WIDTH-1:WIDTH-2];
                end
            end

            // Lower half-cycle (quadrants 2,3) sits below mid-scale.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (vld_reg[1]) begin
                    dout_reg <= q_reg[1] ? (MID - mag_ext) : (MID + mag_ext);
                end
            end
        end
    endgenerate

    assign dout1 = ch[0].dout_reg;
    assign dout2 = ch[1].dout_reg;
    assign valid = vld_reg[2];

endmodule
